// File: rtl/invader_pkg.sv
// -----------------------------------------------------------------------------
// invader_pkg
// Shared constants and types for the invader collision block:
//   - default formation geometry (rows, columns, cell pitch, sprite size)
//   - bullet width (tip sits at bullet_x + width/2)
//   - kill row/column index types for the default geometry
//   - collision FSM state encoding
//   - row_points(): points awarded for a kill in a given formation row
// Optional feature macro used by the top level: INVADER_SCORE_EN.
// -----------------------------------------------------------------------------
package invader_pkg;

  localparam int INV_ROWS     = 5;
  localparam int INV_COLS     = 11;
  localparam int INV_CELL_W   = 32;
  localparam int INV_CELL_H   = 32;
  localparam int INV_SPR_W    = 24;
  localparam int INV_SPR_H    = 16;
  localparam int INV_BULLET_W = 4;

  typedef logic [$clog2(INV_ROWS)-1:0] row_idx_t;
  typedef logic [$clog2(INV_COLS)-1:0] col_idx_t;

  typedef enum logic [0:0] {
    ST_ARMED    = 1'b0,
    ST_HIT_HOLD = 1'b1
  } inv_state_t;

  // Top row is worth the most; the bottom rows are the cheap ones.
  function automatic logic [15:0] row_points(input logic [7:0] row);
    logic [15:0] pts;
    case (row)
      8'd0:       pts = 16'd30;
      8'd1, 8'd2: pts = 16'd20;
      default:    pts = 16'd10;
    endcase
    return pts;
  endfunction

endpackage

// File: rtl/invader_hit_locate.sv
// -----------------------------------------------------------------------------
// invader_hit_locate
// Pipeline stages S1-S2 of the bullet/formation hit test.
//   S1: bullet tip relative to the formation origin (13-bit two's complement).
//   S2: grid cell (row, col), inside-grid flag and inside-sprite flag.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_flush               drop the valid bits of both stages this cycle
//   i_bullet_x/y/active   player bullet (left edge x, tip y, in flight)
//   i_form_x/y            formation origin (top-left of cell 0,0)
//   o_valid               S2 result valid
//   o_row, o_col          cell coordinates (meaningful only with o_in_grid)
//   o_in_grid, o_in_sprite  tip inside the grid / inside the sprite box
// -----------------------------------------------------------------------------
module invader_hit_locate
  import invader_pkg::*;
#(
  parameter int ROWS         = INV_ROWS,
  parameter int COLS         = INV_COLS,
  parameter int CELL_W       = INV_CELL_W,
  parameter int CELL_H       = INV_CELL_H,
  parameter int INV_W        = INV_SPR_W,
  parameter int INV_H        = INV_SPR_H,
  parameter int BULLET_WIDTH = INV_BULLET_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic [11:0]              i_bullet_x,
  input  logic [11:0]              i_bullet_y,
  input  logic                     i_bullet_active,
  input  logic [11:0]              i_form_x,
  input  logic [11:0]              i_form_y,
  output logic                     o_valid,
  output logic [$clog2(ROWS)-1:0]  o_row,
  output logic [$clog2(COLS)-1:0]  o_col,
  output logic                     o_in_grid,
  output logic                     o_in_sprite
);

  localparam int ROW_W  = $clog2(ROWS);
  localparam int COL_W  = $clog2(COLS);
  localparam int CW_LOG = $clog2(CELL_W);
  localparam int CH_LOG = $clog2(CELL_H);

  logic [12:0]      w_rel_x, w_rel_y;
  logic [12:0]      r_rel_x, r_rel_y;
  logic             r_v1;
  logic             w_in_grid, w_in_sprite;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic             r_v2, r_in_grid, r_in_sprite;
  logic [ROW_W-1:0] r_row;
  logic [COL_W-1:0] r_col;

  // S1 arithmetic: bit 12 is the sign, so a bullet left of / above the
  // formation shows up as negative instead of wrapping into the grid.
  always_comb begin
    w_rel_x = {1'b0, i_bullet_x} + 13'(BULLET_WIDTH / 2) - {1'b0, i_form_x};
    w_rel_y = {1'b0, i_bullet_y} - {1'b0, i_form_y};
  end

  // S1 registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v1    <= 1'b0;
      r_rel_x <= 13'd0;
      r_rel_y <= 13'd0;
    end else begin
      r_v1    <= i_flush ? 1'b0 : i_bullet_active;
      r_rel_x <= w_rel_x;
      r_rel_y <= w_rel_y;
    end
  end

  // S2 arithmetic: power-of-two pitches make cell index a shift and the
  // in-cell offset a mask.
  always_comb begin
    w_in_grid   = !r_rel_x[12] && !r_rel_y[12] &&
                  (r_rel_x < 13'(COLS * CELL_W)) && (r_rel_y < 13'(ROWS * CELL_H));
    w_in_sprite = ((r_rel_x & 13'(CELL_W - 1)) < 13'(INV_W)) &&
                  ((r_rel_y & 13'(CELL_H - 1)) < 13'(INV_H));
    w_col       = COL_W'(r_rel_x >> CW_LOG);
    w_row       = ROW_W'(r_rel_y >> CH_LOG);
  end

  // S2 registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v2        <= 1'b0;
      r_in_grid   <= 1'b0;
      r_in_sprite <= 1'b0;
      r_row       <= '0;
      r_col       <= '0;
    end else begin
      r_v2        <= i_flush ? 1'b0 : r_v1;
      r_in_grid   <= w_in_grid;
      r_in_sprite <= w_in_sprite;
      r_row       <= w_row;
      r_col       <= w_col;
    end
  end

  assign o_valid     = r_v2;
  assign o_row       = r_row;
  assign o_col       = r_col;
  assign o_in_grid   = r_in_grid;
  assign o_in_sprite = r_in_sprite;

endmodule

// File: rtl/invader_collision.sv
// -----------------------------------------------------------------------------
// invader_collision
// Player bullet vs. invader formation hit detector. Owns the alive bitmap,
// reports each kill and the wave-cleared status.
// Ports:
//   i_clk, i_rst           clock, synchronous active-high reset
//   i_bullet_x/y/active    player bullet (left edge x, tip y, in flight)
//   i_form_x/y             formation origin
//   i_wave_reload          1-cycle pulse: revive every invader
//   o_bullet_hit           hit level, held until the bullet is retired
//   o_kill_valid           1-cycle pulse per kill, with o_kill_row/o_kill_col
//   o_alive_mask           bit r*COLS+c set = invader (r,c) alive
//   o_wave_clear           registered "no invaders left"
//   o_score                row-weighted saturating score (INVADER_SCORE_EN only)
// Optional feature macro: INVADER_SCORE_EN.
// Latency: bullet sampled at edge N -> o_bullet_hit / o_kill_valid after N+3.
// -----------------------------------------------------------------------------
module invader_collision
  import invader_pkg::*;
#(
  parameter int ROWS         = INV_ROWS,
  parameter int COLS         = INV_COLS,
  parameter int CELL_W       = INV_CELL_W,
  parameter int CELL_H       = INV_CELL_H,
  parameter int INV_W        = INV_SPR_W,
  parameter int INV_H        = INV_SPR_H,
  parameter int BULLET_WIDTH = INV_BULLET_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [11:0]              i_bullet_x,
  input  logic [11:0]              i_bullet_y,
  input  logic                     i_bullet_active,
  input  logic [11:0]              i_form_x,
  input  logic [11:0]              i_form_y,
  input  logic                     i_wave_reload,
  output logic                     o_bullet_hit,
  output logic                     o_kill_valid,
  output logic [$clog2(ROWS)-1:0]  o_kill_row,
  output logic [$clog2(COLS)-1:0]  o_kill_col,
  output logic [ROWS*COLS-1:0]     o_alive_mask,
  output logic                     o_wave_clear
`ifdef INVADER_SCORE_EN
  ,
  output logic [15:0]              o_score
`endif
);

  localparam int ROW_W = $clog2(ROWS);
  localparam int COL_W = $clog2(COLS);
  localparam int CELLS = ROWS * COLS;
  localparam int IDX_W = $clog2(CELLS);

  logic             w_flush;
  logic             w_v2, w_in_grid, w_in_sprite;
  logic [ROW_W-1:0] w_row;
  logic [COL_W-1:0] w_col;
  logic [IDX_W-1:0] w_idx, w_kill_idx;
  logic             w_hit2, w_kill;

  logic             r_hit3;
  logic [ROW_W-1:0] r_row3;
  logic [COL_W-1:0] r_col3;
  inv_state_t       r_state;
  logic             r_bullet_hit, r_kill_valid, r_wave_clear;
  logic [ROW_W-1:0] r_kill_row;
  logic [COL_W-1:0] r_kill_col;
  logic [CELLS-1:0] r_alive;

  // Pipe valids are dropped on reload and when a held hit is released, so a
  // stale in-flight sample can never score against a fresh bullet or wave.
  assign w_flush = i_wave_reload || ((r_state == ST_HIT_HOLD) && !i_bullet_active);

  invader_hit_locate #(
    .ROWS(ROWS), .COLS(COLS), .CELL_W(CELL_W), .CELL_H(CELL_H),
    .INV_W(INV_W), .INV_H(INV_H), .BULLET_WIDTH(BULLET_WIDTH)
  ) u_locate (
    .i_clk(i_clk), .i_rst(i_rst), .i_flush(w_flush),
    .i_bullet_x(i_bullet_x), .i_bullet_y(i_bullet_y), .i_bullet_active(i_bullet_active),
    .i_form_x(i_form_x), .i_form_y(i_form_y),
    .o_valid(w_v2), .o_row(w_row), .o_col(w_col),
    .o_in_grid(w_in_grid), .o_in_sprite(w_in_sprite)
  );

  // Bitmap index for the S2 cell; forced to 0 off-grid so it never exceeds the mask.
  always_comb begin
    if (w_in_grid) begin
      w_idx = IDX_W'(w_row) * IDX_W'(COLS) + IDX_W'(w_col);
    end else begin
      w_idx = '0;
    end
    w_hit2     = w_v2 && w_in_grid && w_in_sprite && r_alive[w_idx];
    w_kill_idx = IDX_W'(r_row3) * IDX_W'(COLS) + IDX_W'(r_col3);
    // Reload wins over a kill landing on the same edge.
    w_kill     = (r_state == ST_ARMED) && r_hit3 && !i_wave_reload;
  end

  // S3 register: hit decision against the current alive bitmap.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hit3 <= 1'b0;
      r_row3 <= '0;
      r_col3 <= '0;
    end else begin
      r_hit3 <= w_flush ? 1'b0 : w_hit2;
      r_row3 <= w_row;
      r_col3 <= w_col;
    end
  end

  // Kill FSM and alive bitmap: one kill per bullet, hit level held until the
  // bullet is seen inactive.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= ST_ARMED;
      r_bullet_hit <= 1'b0;
      r_kill_valid <= 1'b0;
      r_kill_row   <= '0;
      r_kill_col   <= '0;
      r_alive      <= '1;
    end else begin
      r_kill_valid <= 1'b0;
      if (i_wave_reload) begin
        r_alive      <= '1;
        r_state      <= ST_ARMED;
        r_bullet_hit <= 1'b0;
      end else if (w_kill) begin
        r_alive[w_kill_idx] <= 1'b0;
        r_kill_valid        <= 1'b1;
        r_kill_row          <= r_row3;
        r_kill_col          <= r_col3;
        r_bullet_hit        <= 1'b1;
        r_state             <= ST_HIT_HOLD;
      end else if ((r_state == ST_HIT_HOLD) && !i_bullet_active) begin
        r_bullet_hit <= 1'b0;
        r_state      <= ST_ARMED;
      end
    end
  end

  // Wave-clear flag trails the bitmap by one cycle.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wave_clear <= 1'b0;
    end else begin
      r_wave_clear <= (r_alive == '0);
    end
  end

  assign o_bullet_hit = r_bullet_hit;
  assign o_kill_valid = r_kill_valid;
  assign o_kill_row   = r_kill_row;
  assign o_kill_col   = r_kill_col;
  assign o_alive_mask = r_alive;
  assign o_wave_clear = r_wave_clear;

`ifdef INVADER_SCORE_EN
  logic [15:0] r_score;
  logic [16:0] w_score_sum;

  assign w_score_sum = {1'b0, r_score} + {1'b0, row_points(8'(r_row3))};

  // Saturating score; survives wave reloads, cleared only by reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_score <= 16'd0;
    end else if (w_kill) begin
      r_score <= w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];
    end
  end

  assign o_score = r_score;
`endif

endmodule

// File: tb/tb_invader_collision.sv
module tb_invader_collision;
  import invader_pkg::*;

  localparam int R = 5;
  localparam int C = 11;
  localparam int N = R * C;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] bullet_x = 12'd0, bullet_y = 12'd0, form_x = 12'd100, form_y = 12'd64;
  logic        bullet_active = 1'b0, wave_reload = 1'b0;
  logic        bullet_hit, kill_valid, wave_clear;
  logic [2:0]  kill_row;
  logic [3:0]  kill_col;
  logic [N-1:0] alive_mask;
`ifdef INVADER_SCORE_EN
  logic [15:0] score;
`endif

  always #5 clk = ~clk;

  invader_collision dut (
    .i_clk(clk), .i_rst(rst),
    .i_bullet_x(bullet_x), .i_bullet_y(bullet_y), .i_bullet_active(bullet_active),
    .i_form_x(form_x), .i_form_y(form_y), .i_wave_reload(wave_reload),
    .o_bullet_hit(bullet_hit), .o_kill_valid(kill_valid),
    .o_kill_row(kill_row), .o_kill_col(kill_col),
    .o_alive_mask(alive_mask), .o_wave_clear(wave_clear)
`ifdef INVADER_SCORE_EN
    , .o_score(score)
`endif
  );

  typedef struct { int row; int col; } kill_t;
  kill_t        exp_q[$];
  bit           m_alive[N];   // reference formation: true = invader alive
  int           m_score;
  int           fx = 100, fy = 64;
  int           n_cmp = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int pts(input int row);
    if (row == 0) return 30;
    if (row <= 2) return 20;
    return 10;
  endfunction

  function automatic logic [63:0] model_mask();
    logic [63:0] m = 64'd0;
    for (int i = 0; i < N; i++) m[i] = m_alive[i];
    return m;
  endfunction

  function automatic bit model_all_dead();
    for (int i = 0; i < N; i++) if (m_alive[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
    m_score = 0;
  endtask

  // Monitor: every kill pulse the DUT presents is matched against the queue.
  always @(negedge clk) begin
    if (kill_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_kill: got row %0d col %0d expected none", kill_row, kill_col);
      end else begin
        kill_t e;
        e = exp_q.pop_front();
        chk("kill_row", 64'(kill_row), 64'(e.row));
        chk("kill_col", 64'(kill_col), 64'(e.col));
      end
    end
  end

  // One bullet: held in place for the latency plus 'hold' cycles, then retired.
  task automatic shot(input int bx, input int by, input int hold);
    int  rx, ry, r, c;
    bit  hit;
    rx  = bx + 2 - fx;
    ry  = by - fy;
    hit = (rx >= 0) && (rx < C * 32) && (ry >= 0) && (ry < R * 32) &&
          (rx % 32 < 24) && (ry % 32 < 16);
    r = 0;
    c = 0;
    if (hit) begin
      r   = ry / 32;
      c   = rx / 32;
      hit = m_alive[r * C + c];
    end
    if (hit) begin
      kill_t k;
      k.row = r;
      k.col = c;
      exp_q.push_back(k);
      m_alive[r * C + c] = 1'b0;
      m_score = (m_score + pts(r) > 65535) ? 65535 : m_score + pts(r);
    end
    @(negedge clk);
    form_x = 12'(fx);
    form_y = 12'(fy);
    bullet_x = 12'(bx);
    bullet_y = 12'(by);
    bullet_active = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("hit_early", 64'(bullet_hit), 64'd0);
    @(posedge clk);
    #1 chk("hit_latency", 64'(bullet_hit), 64'(hit));
    repeat (hold) @(posedge clk);
    #1 chk("hit_held", 64'(bullet_hit), 64'(hit));
    @(negedge clk);
    bullet_active = 1'b0;
    @(posedge clk);
    #1 chk("hit_release", 64'(bullet_hit), 64'd0);
    chk("alive_mask", 64'(alive_mask), model_mask());
    @(posedge clk);
    #1 chk("wave_clear", 64'(wave_clear), 64'(model_all_dead()));
`ifdef INVADER_SCORE_EN
    chk("score", 64'(score), 64'(m_score));
`endif
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_hit"},   64'(bullet_hit), 64'd0);
    chk({tag, "_kv"},    64'(kill_valid), 64'd0);
    chk({tag, "_row"},   64'(kill_row),   64'd0);
    chk({tag, "_col"},   64'(kill_col),   64'd0);
    chk({tag, "_mask"},  64'(alive_mask), {{(64-N){1'b0}}, {N{1'b1}}});
    chk({tag, "_clear"}, 64'(wave_clear), 64'd0);
`ifdef INVADER_SCORE_EN
    chk({tag, "_score"}, 64'(score), 64'd0);
`endif
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 check_reset_state("reset");

    // Directed geometry cases at form (100,64).
    fx = 100; fy = 64;
    shot(200, 130, 1000);                 // row 2, col 3, long hold -> single kill
    chk("bit25_dead", 64'(alive_mask[25]), 64'd0);
    shot(218, 130, 2);                    // tip 220: column gap
    shot(200, 150, 2);                    // row gap
    shot(200, 130, 2);                    // same cell, already dead
    shot(60, 130, 2);                     // left of formation

    // Randomised shots around and inside the formation.
    repeat (150) begin
      int r, c, bx, by;
      if ($urandom_range(0, 9) == 0) begin
        fx = int'($urandom_range(100, 300));
        fy = int'($urandom_range(40, 200));
      end
      r  = int'($urandom_range(0, R + 1)) - 1;
      c  = int'($urandom_range(0, C + 1)) - 1;
      bx = fx + c * 32 + int'($urandom_range(0, 31)) - 2;
      by = fy + r * 32 + int'($urandom_range(0, 31));
      shot(bx, by, int'($urandom_range(1, 8)));
    end

    // Sweep every cell centre to clear the wave.
    fx = 100; fy = 64;
    for (int r = 0; r < R; r++)
      for (int c = 0; c < C; c++)
        shot(fx + c * 32 + 10, fy + r * 32 + 5, 1);
    chk("wave_clear_all", 64'(wave_clear), 64'd1);

    // Wave reload revives everything; wave_clear follows a cycle later.
    @(negedge clk);
    wave_reload = 1'b1;
    @(negedge clk);
    wave_reload = 1'b0;
    model_reset_mask_only();
    chk("reload_mask", 64'(alive_mask), model_mask());
    @(posedge clk);
    #1 chk("reload_clear", 64'(wave_clear), 64'd0);

    // Reload on the same edge as a pending kill: reload wins.
    @(negedge clk);
    bullet_x = 12'(fx + 8);
    bullet_y = 12'(fy + 5);
    bullet_active = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    wave_reload = 1'b1;
    bullet_active = 1'b0;
    @(posedge clk);
    #1 wave_reload = 1'b0;
    chk("race_kv", 64'(kill_valid), 64'd0);
    chk("race_hit", 64'(bullet_hit), 64'd0);
    repeat (5) @(posedge clk);
    #1 chk("race_mask", 64'(alive_mask), model_mask());

    // Reset while holding a hit.
    begin
      kill_t k;
      k.row = 1;
      k.col = 1;
      exp_q.push_back(k);
    end
    @(negedge clk);
    bullet_x = 12'(fx + 32 + 8);
    bullet_y = 12'(fy + 32 + 5);
    bullet_active = 1'b1;
    repeat (4) @(posedge clk);
    #1 chk("hold_before_rst", 64'(bullet_hit), 64'd1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bullet_active = 1'b0;
    @(posedge clk);
    #1 check_reset_state("midhold_rst");
    @(negedge clk);
    rst = 1'b0;
    model_reset();

`ifdef INVADER_SCORE_EN
    fx = 100; fy = 64;
    shot(fx + 5 * 32 + 8, fy + 0 * 32 + 5, 1);
    chk("score_row0", 64'(score), 64'd30);
    shot(fx + 5 * 32 + 8, fy + 1 * 32 + 5, 1);
    chk("score_row1", 64'(score), 64'd50);
    shot(fx + 5 * 32 + 8, fy + 4 * 32 + 5, 1);
    chk("score_row4", 64'(score), 64'd60);
`endif

    repeat (3) @(posedge clk);
    #1 chk("kills_outstanding", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  task automatic model_reset_mask_only();
    for (int i = 0; i < N; i++) m_alive[i] = 1'b1;
  endtask

endmodule
